// File: rtl/sakebi_xmii_rx.sv
// RMII/MII receive front end: strips preamble/SFD, packs bytes LSB-first, emits AXIS frames.
// Latency: a byte is written when the next byte completes or CRS_DV drops; TVALID follows one clock later.
// Backpressure: a frame FIFO absorbs TREADY stalls; FIFO overflow truncates the frame and appends a bad terminator.
module sakebi_xmii_rx #(
  parameter int RXD_W      = 2,    // 2 = RMII, 4 = MII
  parameter int FIFO_DEPTH = 16,   // power of two, >= 4
  parameter int MIN_FRAME  = 64,
  parameter int MAX_FRAME  = 1522
) (
  input  logic             i_axis_ACLK,
  input  logic             i_axis_ARESETn,
  input  logic             i_rmii_CRS_DV,
  input  logic [RXD_W-1:0] i_rmii_RXD,
  output logic             o_axis_TVALID,
  input  logic             i_axis_TREADY,
  output logic [7:0]       o_axis_TDATA,
  output logic             o_axis_TLAST,
  output logic             o_axis_TUSER,
  output logic [15:0]      o_err_count
);

  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam int               SPB      = 8 / RXD_W;
  localparam logic [1:0]       LAST_SYM = 2'(SPB - 1);
  localparam logic [RXD_W-1:0] PRE_SYM  = (RXD_W == 2) ? RXD_W'(1) : RXD_W'(5);
  localparam logic [RXD_W-1:0] SFD_SYM  = (RXD_W == 2) ? RXD_W'(3) : RXD_W'(13);
  localparam logic [10:0]      BYTE_MAX = 11'h7ff;
  localparam logic [10:0]      MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [10:0]      OVER_LEN = 11'(MAX_FRAME + 1);
  localparam logic [AW:0]      FULL_OCC = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    DROP,
    TERM
  } state_t;

  // ---------------------------------------------------------------------------
  // Frame FIFO: storage array plus a registered head stage. Occupancy counts
  // the head register too, so FIFO_DEPTH is the total number of beats held.
  // ---------------------------------------------------------------------------
  beat_t         mem [FIFO_DEPTH];
  beat_t         head;
  logic          head_vld;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   mem_cnt;
  logic          rd_fire;
  logic          load;
  logic          can_write;
  logic          wr_req;
  logic          wr_vld;
  beat_t         wr_dat;

  assign rd_fire   = head_vld & i_axis_TREADY;
  // A beat leaving the head this cycle frees a slot, so a full FIFO can still take a write.
  assign can_write = (occ != FULL_OCC) | rd_fire;
  assign wr_vld    = wr_req & can_write;
  assign mem_cnt   = occ - {{AW{1'b0}}, head_vld};
  assign load      = (mem_cnt != '0) & (~head_vld | i_axis_TREADY);

  // Storage array write; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge i_axis_ACLK) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  // Pointers, occupancy and the registered first-word-fall-through head
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      head     <= '0;
      head_vld <= 1'b0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        head     <= mem[rd_ptr];
        head_vld <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
      end else if (rd_fire) begin
        head_vld <= 1'b0;
      end
      case ({wr_vld, rd_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign o_axis_TVALID = head_vld;
  assign o_axis_TDATA  = head.data;
  assign o_axis_TLAST  = head.last;
  assign o_axis_TUSER  = head.user;

  // ---------------------------------------------------------------------------
  // Receive framer
  // ---------------------------------------------------------------------------
  state_t      state;
  logic        pre_seen;    // at least one preamble symbol seen
  logic        in_data;     // frame reached DATA, so a drop owes a terminator
  logic        err_sticky;
  logic [1:0]  sym_cnt;
  logic [7:0]  byte_reg;
  logic [7:0]  byte_nxt;
  logic [7:0]  hold;
  logic        hold_vld;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic        byte_done;
  logic        over_len;
  logic        eof_bad;

  assign byte_done    = (state == DATA) & i_rmii_CRS_DV & (sym_cnt == LAST_SYM);
  assign byte_cnt_inc = (byte_cnt == BYTE_MAX) ? byte_cnt : byte_cnt + 11'd1;
  assign over_len     = byte_done & (byte_cnt_inc == OVER_LEN);
  assign eof_bad      = (sym_cnt != 2'd0) | (byte_cnt < MIN_LEN) | err_sticky;

  // Byte assembly: the current symbol lands in its LSB-first slot
  always_comb begin
    byte_nxt = byte_reg;
    byte_nxt[int'(sym_cnt) * RXD_W +: RXD_W] = i_rmii_RXD;
  end

  // FIFO write request: held byte on next byte / end of frame, or a terminator
  always_comb begin
    wr_req = 1'b0;
    wr_dat = '0;
    case (state)
      DATA: begin
        if (!i_rmii_CRS_DV) begin
          wr_req      = 1'b1;
          wr_dat.last = 1'b1;
          // An empty frame still produces a single bad beat so downstream sees the event.
          wr_dat.user = hold_vld ? eof_bad : 1'b1;
          wr_dat.data = hold_vld ? hold : 8'h00;
        end else if (byte_done && hold_vld) begin
          wr_req      = 1'b1;
          wr_dat.data = hold;
        end
      end
      TERM: begin
        wr_req      = 1'b1;
        wr_dat.user = 1'b1;
        wr_dat.last = 1'b1;
      end
      default: ;
    endcase
  end

  // Receive state machine with its datapath registers
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      state      <= WAIT_IDLE;
      pre_seen   <= 1'b0;
      in_data    <= 1'b0;
      err_sticky <= 1'b0;
      sym_cnt    <= 2'd0;
      byte_reg   <= 8'h00;
      hold       <= 8'h00;
      hold_vld   <= 1'b0;
      byte_cnt   <= 11'd0;
    end else begin
      case (state)
        // Never join a frame midway: wait for carrier to go away first.
        WAIT_IDLE: begin
          if (!i_rmii_CRS_DV) state <= IDLE;
        end
        IDLE: begin
          in_data <= 1'b0;
          if (i_rmii_CRS_DV) begin
            state    <= PREAMBLE;
            pre_seen <= (i_rmii_RXD == PRE_SYM);
          end
        end
        PREAMBLE: begin
          if (!i_rmii_CRS_DV) begin
            state <= DROP;
          end else if (i_rmii_RXD == SFD_SYM && pre_seen) begin
            state      <= DATA;
            in_data    <= 1'b1;
            err_sticky <= 1'b0;
            sym_cnt    <= 2'd0;
            byte_reg   <= 8'h00;
            hold_vld   <= 1'b0;
            byte_cnt   <= 11'd0;
          end else if (i_rmii_RXD == PRE_SYM) begin
            pre_seen <= 1'b1;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (!i_rmii_CRS_DV) begin
            if (can_write) begin
              state <= IDLE;
            end else begin
              err_sticky <= 1'b1;
              state      <= DROP;
            end
          end else begin
            byte_reg <= byte_nxt;
            sym_cnt  <= byte_done ? 2'd0 : sym_cnt + 2'd1;
            if (byte_done) begin
              byte_cnt <= byte_cnt_inc;
              hold     <= byte_nxt;
              hold_vld <= 1'b1;
              if ((hold_vld && !can_write) || over_len) begin
                err_sticky <= 1'b1;
                state      <= DROP;
              end
            end
          end
        end
        DROP: begin
          if (!i_rmii_CRS_DV) state <= in_data ? TERM : IDLE;
        end
        // A frame starting while the terminator waits is skipped via WAIT_IDLE.
        TERM: begin
          if (can_write) begin
            in_data <= 1'b0;
            state   <= i_rmii_CRS_DV ? WAIT_IDLE : IDLE;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

  // Saturating count of bad frames actually written to the FIFO
  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      o_err_count <= 16'd0;
    end else if (wr_vld && wr_dat.last && wr_dat.user && o_err_count != 16'hffff) begin
      o_err_count <= o_err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sakebi_xmii_rx.sv
// Directed bench for sakebi_xmii_rx: one RMII and one MII instance.
// Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge.
// Every comparison goes through check(); the summary line reports the totals.
`timescale 1ns/1ps
module tb_sakebi_xmii_rx;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // RMII instance: small FIFO and short max frame to reach the overflow/over-length cases
  logic       crs_r;
  logic [1:0] rxd_r;
  logic       tr_r, tv_r, tl_r, tu_r;
  logic [7:0] td_r;
  logic [15:0] ec_r;

  // MII instance
  logic       crs_m;
  logic [3:0] rxd_m;
  logic       tr_m, tv_m, tl_m, tu_m;
  logic [7:0] td_m;
  logic [15:0] ec_m;

  sakebi_xmii_rx #(.RXD_W(2), .FIFO_DEPTH(4), .MIN_FRAME(4), .MAX_FRAME(8)) dut_rmii (
    .i_axis_ACLK    (clk),
    .i_axis_ARESETn (rst_n),
    .i_rmii_CRS_DV  (crs_r),
    .i_rmii_RXD     (rxd_r),
    .o_axis_TVALID  (tv_r),
    .i_axis_TREADY  (tr_r),
    .o_axis_TDATA   (td_r),
    .o_axis_TLAST   (tl_r),
    .o_axis_TUSER   (tu_r),
    .o_err_count    (ec_r)
  );

  sakebi_xmii_rx #(.RXD_W(4), .FIFO_DEPTH(16), .MIN_FRAME(4), .MAX_FRAME(1522)) dut_mii (
    .i_axis_ACLK    (clk),
    .i_axis_ARESETn (rst_n),
    .i_rmii_CRS_DV  (crs_m),
    .i_rmii_RXD     (rxd_m),
    .o_axis_TVALID  (tv_m),
    .i_axis_TREADY  (tr_m),
    .o_axis_TDATA   (td_m),
    .o_axis_TLAST   (tl_m),
    .o_axis_TUSER   (tu_m),
    .o_err_count    (ec_m)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  int unsigned start_r, start_m, first_r, first_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Captured beats as {user, last, data}
  logic [9:0] rx_r[$];
  logic [9:0] rx_m[$];
  logic [9:0] exp_q[$];
  logic [7:0] tx[$];

  always @(negedge clk) begin
    if (rst_n && tv_r && tr_r) begin
      if (rx_r.size() == 0) first_r = cyc;
      rx_r.push_back({tu_r, tl_r, td_r});
    end
    if (rst_n && tv_m && tr_m) begin
      if (rx_m.size() == 0) first_m = cyc;
      rx_m.push_back({tu_m, tl_m, td_m});
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic r_sym(input logic c, input logic [1:0] d);
    crs_r = c;
    rxd_r = d;
    tick();
  endtask

  task automatic m_sym(input logic c, input logic [3:0] d);
    crs_m = c;
    rxd_m = d;
    tick();
  endtask

  task automatic r_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) r_sym(1'b1, b[2*i +: 2]);
  endtask

  task automatic m_byte(input logic [7:0] b);
    m_sym(1'b1, b[3:0]);
    m_sym(1'b1, b[7:4]);
  endtask

  task automatic r_idle(input int n);
    repeat (n) r_sym(1'b0, 2'b00);
  endtask

  task automatic m_idle(input int n);
    repeat (n) m_sym(1'b0, 4'h0);
  endtask

  // Preamble + SFD, the bytes in tx, optional trailing 01 dibits, then carrier off
  task automatic r_frame(input int extra);
    start_r = cyc;
    for (int i = 0; i < 7; i++) r_byte(8'h55);
    r_byte(8'hD5);
    foreach (tx[i]) r_byte(tx[i]);
    for (int i = 0; i < extra; i++) r_sym(1'b1, 2'b01);
    r_sym(1'b0, 2'b00);
  endtask

  task automatic m_frame();
    start_m = cyc;
    for (int i = 0; i < 7; i++) m_byte(8'h55);
    m_byte(8'hD5);
    foreach (tx[i]) m_byte(tx[i]);
    m_sym(1'b0, 4'h0);
  endtask

  // Compare captured beats of one instance against exp_q, then clear both
  task automatic cmp(input logic mii, input string tag);
    logic [9:0] got[$];
    got = mii ? rx_m : rx_r;
    check({tag, " beats"}, got.size(), exp_q.size());
    foreach (exp_q[i])
      check($sformatf("%s beat%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
    if (mii) rx_m.delete(); else rx_r.delete();
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    crs_r = 1'b0; rxd_r = 2'b00; tr_r = 1'b1;
    crs_m = 1'b0; rxd_m = 4'h0;  tr_m = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Reset values
    check("rst tvalid", tv_r, 1'b0);
    check("rst tdata",  td_r, 8'h00);
    check("rst tlast",  tl_r, 1'b0);
    check("rst tuser",  tu_r, 1'b0);
    check("rst errcnt", ec_r, 16'h0000);
    check("rst mii tvalid", tv_m, 1'b0);
    check("rst mii errcnt", ec_m, 16'h0000);
    rst_n = 1'b1;
    tick();
    tick();

    // RMII good frame
    tx = '{8'h12, 8'h34, 8'h56, 8'h78};
    r_frame(0);
    r_idle(20);
    check("rmii first-beat latency", first_r - start_r, 32'd41);
    exp_q = '{10'h012, 10'h034, 10'h056, 10'h178};
    cmp(1'b0, "rmii good");
    check("rmii good errcnt", ec_r, 16'd0);

    // MII same frame, half the symbol count
    m_frame();
    m_idle(20);
    check("mii first-beat latency", first_m - start_m, 32'd21);
    exp_q = '{10'h012, 10'h034, 10'h056, 10'h178};
    cmp(1'b1, "mii good");
    check("mii good errcnt", ec_m, 16'd0);

    // Runt frame, then a frame with a dribble dibit
    tx = '{8'hA1, 8'hB2, 8'hC3};
    r_frame(0);
    r_idle(6);
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    r_frame(1);
    r_idle(20);
    exp_q = '{10'h0A1, 10'h0B2, 10'h3C3, 10'h011, 10'h022, 10'h033, 10'h344};
    cmp(1'b0, "runt+dribble");
    check("runt+dribble errcnt", ec_r, 16'd2);

    // FIFO overflow with TREADY low
    tr_r = 1'b0;
    tx.delete();
    for (int i = 1; i <= 10; i++) tx.push_back(8'(i));
    r_frame(0);
    r_idle(10);
    check("ovf head valid", tv_r, 1'b1);
    check("ovf head data",  td_r, 8'h01);
    check("ovf head last",  tl_r, 1'b0);
    check("ovf no transfer", rx_r.size(), 0);
    check("ovf errcnt before term", ec_r, 16'd2);
    tr_r = 1'b1;
    r_idle(15);
    exp_q = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h300};
    cmp(1'b0, "ovf");
    check("ovf errcnt", ec_r, 16'd3);

    // Over-length frame, then a normal frame
    tx.delete();
    for (int i = 0; i < 12; i++) tx.push_back(8'(8'h21 + i));
    r_frame(0);
    r_idle(20);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(10'(8'h21 + i));
    exp_q.push_back(10'h300);
    cmp(1'b0, "overlen");
    check("overlen errcnt", ec_r, 16'd4);
    tx = '{8'h5A, 8'h5B, 8'h5C, 8'h5D};
    r_frame(0);
    r_idle(20);
    exp_q = '{10'h05A, 10'h05B, 10'h05C, 10'h15D};
    cmp(1'b0, "after overlen");
    check("after overlen errcnt", ec_r, 16'd4);

    // Reset in the middle of DATA, released with carrier still up
    tr_r = 1'b0;
    for (int i = 0; i < 7; i++) r_byte(8'h55);
    r_byte(8'hD5);
    r_byte(8'h31);
    r_byte(8'h32);
    r_byte(8'h33);
    check("pre-reset tvalid", tv_r, 1'b1);
    check("pre-reset tdata",  td_r, 8'h31);
    rst_n = 1'b0;
    r_sym(1'b1, 2'b01);
    r_sym(1'b1, 2'b00);
    check("in-reset tvalid", tv_r, 1'b0);
    check("in-reset tdata",  td_r, 8'h00);
    check("in-reset tlast",  tl_r, 1'b0);
    check("in-reset tuser",  tu_r, 1'b0);
    check("in-reset errcnt", ec_r, 16'd0);
    rst_n = 1'b1;
    tr_r = 1'b1;
    r_byte(8'h35);
    r_byte(8'h36);
    r_idle(20);
    check("cut frame not delivered", rx_r.size(), 0);
    tx = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
    r_frame(0);
    r_idle(20);
    exp_q = '{10'h09A, 10'h0BC, 10'h0DE, 10'h1F0};
    cmp(1'b0, "after reset");
    check("after reset errcnt", ec_r, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
